axi_burst_rd_master: RTL and testbench

//  AXI read master (DMA reader) that drives the AR/R channels of an AXI slave such as the SRAM/DRAM model.

---
 rtl/axi_burst_rd_master.sv | 188 ++++++++++++++++++
 tb/tb_axi_burst_rd_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_rd_master.sv
// AXI4 burst read master: splits one read command into INCR bursts
// that never cross a 4KB page and streams the returned beats out.
module axi_burst_rd_master #(
    parameter int A         = 32,
    parameter int I         = 4,
    parameter int L         = 8,
    parameter int D         = 512,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16,
    parameter int RD_ID     = 0
) (
    input  logic             ACLK,
    input  logic             ARESET,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [A-1:0]     cmd_addr,
    input  logic [CNT_W-1:0] cmd_beats,

    output logic [I-1:0]     ARID,
    output logic [A-1:0]     ARADDR,
    output logic [L-1:0]     ARLEN,
    output logic [2:0]       ARSIZE,
    output logic [1:0]       ARBURST,
    output logic [1:0]       ARLOCK,
    output logic [3:0]       ARCACHE,
    output logic [2:0]       ARPROT,
    output logic             ARVALID,
    input  logic             ARREADY,

    input  logic [I-1:0]     RID,
    input  logic [D-1:0]     RDATA,
    input  logic [1:0]       RRESP,
    input  logic             RLAST,
    input  logic             RVALID,
    output logic             RREADY,

    output logic [D-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,

    output logic             done,
    output logic             err
);

    localparam int M          = D / 8;
    localparam int LSB        = $clog2(M);
    localparam int PW         = 12 - LSB;
    localparam int PAGE_BEATS = 4096 / M;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [A-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [L-1:0]     len_q, len_d;
    logic [L-1:0]     beat_q, beat_d;
    logic             err_q, err_d;

    logic             r_hs;
    logic             burst_end;

    // Beats in the next burst: limited by what is left, the burst cap
    // and the beats remaining before the next 4KB page boundary.
    function automatic logic [CNT_W-1:0] burst_beats(
        input logic [PW-1:0]    pg_off,
        input logic [CNT_W-1:0] rem
    );
        logic [CNT_W-1:0] page_left;
        logic [CNT_W-1:0] n;
        page_left = CNT_W'(PAGE_BEATS) - CNT_W'(pg_off);
        n = rem;
        if (n > CNT_W'(MAX_BURST)) begin
            n = CNT_W'(MAX_BURST);
        end
        if (n > page_left) begin
            n = page_left;
        end
        return n;
    endfunction

    assign r_hs      = (state_q == S_DATA) && RVALID && out_ready;
    assign burst_end = (beat_q == len_q);

    // Next-state, address, counters and sticky error.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    err_d  = 1'b0;
                    addr_d = {cmd_addr[A-1:LSB], {LSB{1'b0}}};
                    rem_d  = cmd_beats;
                    beat_d = '0;
                    if (cmd_beats == '0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d = L'(burst_beats(cmd_addr[11:LSB], cmd_beats)
                                   - CNT_W'(1));
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (ARREADY) begin
                    addr_d  = addr_q + ((A'(len_q) + A'(1)) << LSB);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    rem_d  = rem_q - CNT_W'(1);
                    beat_d = beat_q + L'(1);
                    if ((RRESP != 2'b00) || (RLAST != burst_end)) begin
                        err_d = 1'b1;
                    end
                    if (burst_end) begin
                        beat_d = '0;
                        if (rem_d == '0) begin
                            state_d = S_DONE;
                        end else begin
                            len_d = L'(burst_beats(addr_q[11:LSB], rem_d)
                                       - CNT_W'(1));
                            state_d = S_ADDR;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any burst in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign ARID    = I'(RD_ID);
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = 3'(LSB);
    assign ARBURST = 2'b01;
    assign ARLOCK  = 2'b00;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = 3'b000;
    assign ARVALID = (state_q == S_ADDR);

    assign RREADY    = (state_q == S_DATA) && out_ready;
    assign out_valid = (state_q == S_DATA) && RVALID;
    assign out_data  = RDATA;
    assign out_last  = out_valid && (rem_q == CNT_W'(1));

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

    logic unused_ok;
    assign unused_ok = ^{RID, cmd_addr[LSB-1:0]};

endmodule

// File: tb/tb_axi_burst_rd_master.sv
// Directed bench for axi_burst_rd_master with a small one-outstanding
// AXI read slave; beat data encodes the beat byte address.
module tb_axi_burst_rd_master;

    localparam int A     = 32;
    localparam int D     = 512;
    localparam int CNT_W = 16;

    logic             ACLK = 1'b0;
    logic             ARESET = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [A-1:0]     cmd_addr = '0;
    logic [CNT_W-1:0] cmd_beats = '0;
    logic [3:0]       ARID;
    logic [A-1:0]     ARADDR;
    logic [7:0]       ARLEN;
    logic [2:0]       ARSIZE;
    logic [1:0]       ARBURST;
    logic [1:0]       ARLOCK;
    logic [3:0]       ARCACHE;
    logic [2:0]       ARPROT;
    logic             ARVALID;
    logic             ARREADY = 1'b0;
    logic [3:0]       RID = '0;
    logic [D-1:0]     RDATA = '0;
    logic [1:0]       RRESP = '0;
    logic             RLAST = 1'b0;
    logic             RVALID = 1'b0;
    logic             RREADY;
    logic [D-1:0]     out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;
    logic             done;
    logic             err;

    axi_burst_rd_master dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
        .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .done(done), .err(err)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    int ar_delay = 0;
    int err_beat = -1;
    bit ready_rand = 1'b0;
    bit rlast_kill = 1'b0;

    bit         s_active = 1'b0;
    logic [A-1:0] s_addr = '0;
    int         s_len = 0;
    int         s_idx = 0;
    int         gbeat = 0;
    int         ar_wait = 0;

    bit           p_ar = 1'b0;
    bit           p_r = 1'b0;
    logic [A-1:0] p_ar_addr = '0;
    int           p_ar_len = 0;

    logic [A-1:0] ar_addr [8];
    int           ar_len [8];
    int           ar_n = 0;
    int           arv_cycles = 0;
    bit           prev_arv_wait = 1'b0;
    logic [39:0]  prev_ar = '0;

    bit           cmd_pending = 1'b0;
    logic [A-1:0] base = '0;
    int           exp_total = 0;
    int           out_cnt = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           last_cyc = 0;
    int           acc_cyc = -100;
    logic         err_post = 1'bx;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: commit handshakes of the last edge, drive, then predict.
    task automatic cycle();
        @(negedge ACLK);
        cyc++;
        if (ARESET) begin
            s_active = 1'b0;
            ar_wait  = 0;
        end else begin
            if (p_ar) begin
                s_active = 1'b1;
                s_addr   = p_ar_addr;
                s_len    = p_ar_len;
                s_idx    = 0;
                if (ar_n < 8) begin
                    ar_addr[ar_n] = p_ar_addr;
                    ar_len[ar_n]  = p_ar_len;
                end
                ar_n++;
            end
            if (p_r) begin
                s_idx++;
                gbeat++;
                if (s_idx > s_len) s_active = 1'b0;
            end
        end
        if (ARVALID && !ARESET) begin
            ARREADY = (ar_wait >= ar_delay);
            ar_wait++;
        end else begin
            ARREADY = 1'b0;
            ar_wait = 0;
        end
        if (s_active) begin
            RVALID = 1'b1;
            RDATA  = {8{64'(s_addr + A'(s_idx * 64))}};
            RLAST  = !rlast_kill && (s_idx == s_len);
            RRESP  = (gbeat == err_beat) ? 2'b10 : 2'b00;
        end else begin
            RVALID = 1'b0;
            RDATA  = '0;
            RLAST  = 1'b0;
            RRESP  = 2'b00;
        end
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        cmd_valid = cmd_pending;
        #1;
        p_ar      = ARVALID && ARREADY;
        p_ar_addr = ARADDR;
        p_ar_len  = int'(ARLEN);
        if (ARVALID) begin
            arv_cycles++;
            if (prev_arv_wait) check("ar_stable", {ARLEN, ARADDR}, prev_ar);
        end
        prev_arv_wait = ARVALID && !ARREADY;
        prev_ar       = {ARLEN, ARADDR};
        p_r = RVALID && RREADY;
        if (out_valid && out_ready) begin
            check("out_data", out_data[63:0], 64'(base + A'(out_cnt * 64)));
            check("out_last", out_last, out_cnt == exp_total - 1);
            if (out_last) last_cyc = cyc;
            out_cnt++;
        end
        if (cmd_valid && cmd_ready) begin
            cmd_pending = 1'b0;
            acc_cyc     = cyc;
        end
        if (cyc == acc_cyc + 1) err_post = err;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic arm(input logic [A-1:0] addr, input int beats);
        base       = {addr[A-1:6], 6'b0};
        exp_total  = beats;
        cmd_addr   = addr;
        cmd_beats  = CNT_W'(beats);
        ar_n       = 0;
        arv_cycles = 0;
        out_cnt    = 0;
        done_cnt   = 0;
        gbeat      = 0;
        last_cyc   = -100;
        done_cyc   = -200;
        acc_cyc    = -100;
        err_post   = 1'bx;
        for (int i = 0; i < 8; i++) begin
            ar_addr[i] = '1;
            ar_len[i]  = -1;
        end
        cmd_pending = 1'b1;
    endtask

    task automatic run(input logic [A-1:0] addr, input int beats,
                       input int budget);
        arm(addr, beats);
        for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
        check("done_seen", done_cnt, 1);
        cycle();
        cycle();
        check("done_pulse", done_cnt, 1);
        check("cmd_ready", cmd_ready, 1'b1);
        check("beats", out_cnt, beats);
        check("err_clr", err_post, 1'b0);
    endtask

    initial begin
        cycle();
        cycle();
        check("rst_arvalid", ARVALID, 1'b0);
        check("rst_rready", RREADY, 1'b0);
        check("rst_oval", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cready", cmd_ready, 1'b1);
        check("ar_const", {ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT},
              {4'd0, 3'd6, 2'b01, 2'b00, 4'd0, 3'd0});
        ARESET = 1'b0;
        cycle();

        run(32'h0, 40, 200);
        check("t1_nar", ar_n, 3);
        check("t1_a0", ar_addr[0], 32'h000);
        check("t1_l0", ar_len[0], 15);
        check("t1_a1", ar_addr[1], 32'h400);
        check("t1_l1", ar_len[1], 15);
        check("t1_a2", ar_addr[2], 32'h800);
        check("t1_l2", ar_len[2], 7);
        check("t1_done_lat", done_cyc - last_cyc, 1);
        check("t1_err", err, 1'b0);

        run(32'hF80, 5, 100);
        check("t2_nar", ar_n, 2);
        check("t2_a0", ar_addr[0], 32'hF80);
        check("t2_l0", ar_len[0], 1);
        check("t2_a1", ar_addr[1], 32'h1000);
        check("t2_l1", ar_len[1], 2);

        ready_rand = 1'b1;
        ar_delay   = 3;
        run(32'h2000, 16, 300);
        check("t3_nar", ar_n, 1);
        check("t3_l0", ar_len[0], 15);
        check("t3_arv_cyc", arv_cycles, 4);
        ready_rand = 1'b0;
        ar_delay   = 0;

        run(32'h40, 0, 20);
        check("t4_nar", ar_n, 0);
        check("t4_arv", arv_cycles, 0);
        check("t4_done_lat", done_cyc - acc_cyc, 1);

        err_beat = 2;
        run(32'h0, 8, 100);
        check("t5_err", err, 1'b1);
        cycle();
        check("t5_err_hold", err, 1'b1);
        err_beat = -1;

        rlast_kill = 1'b1;
        run(32'h1000, 4, 100);
        check("t7_rlast_err", err, 1'b1);
        rlast_kill = 1'b0;

        err_beat = 1;
        arm(32'h0, 16);
        for (int i = 0; i < 100 && out_cnt < 5; i++) cycle();
        check("t6_pre_cnt", out_cnt, 5);
        check("t6_pre_err", err, 1'b1);
        ARESET = 1'b1;
        cycle();
        check("t6_arvalid", ARVALID, 1'b0);
        check("t6_rready", RREADY, 1'b0);
        check("t6_oval", out_valid, 1'b0);
        check("t6_cready", cmd_ready, 1'b1);
        check("t6_err", err, 1'b0);
        ARESET   = 1'b0;
        err_beat = -1;
        cycle();

        run(32'h100, 2, 50);
        check("t6_nar", ar_n, 1);
        check("t6_a0", ar_addr[0], 32'h100);
        check("t6_l0", ar_len[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
